// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem req/ack fetch, one-entry decode buffer
// A redirect during an outstanding request parks in DRAIN until the stale ack arrives.
module fetch_unit #(
    parameter int                     PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req,
    output logic [PC_WIDTH-1:0]       imem_addr,
    input  logic                      imem_ack,
    input  logic [7:0]                imem_rdata,
    input  logic                      redirect_valid,
    input  logic [PC_WIDTH-1:0]       redirect_pc,
    input  logic                      halt,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [4:0]                instr_opcode,
    output logic [2:0]                instr_operand,
    output logic [PC_WIDTH-1:0]       instr_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_HOLD,
        S_HALTED
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   r_drain_addr;
    logic [7:0]            r_ir;
    logic [PC_WIDTH-1:0]   r_instr_pc;
    logic                  r_instr_valid;

    assign imem_req      = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign imem_addr     = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
    assign instr_valid   = r_instr_valid;
    assign instr_opcode  = r_ir[7:3];
    assign instr_operand = r_ir[2:0];
    assign instr_pc      = r_instr_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_drain_addr  <= '0;
            r_ir          <= 8'h00;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else if (redirect_valid) begin
            r_pc          <= redirect_pc;
            r_instr_valid <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (imem_ack) begin
                        r_state <= S_FETCH;
                    end else begin
                        // The old address must stay on the bus until memory answers it.
                        r_drain_addr <= r_pc;
                        r_state      <= S_DRAIN;
                    end
                end
                S_DRAIN:  r_state <= imem_ack ? S_FETCH : S_DRAIN;
                S_HALTED: r_state <= S_HALTED;
                default:  r_state <= S_FETCH;
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= halt ? S_HALTED : S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_ir          <= imem_rdata;
                        r_instr_pc    <= r_pc;
                        r_pc          <= r_pc + PC_ONE;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_HOLD;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        r_state <= S_FETCH;
                    end
                end
                S_HOLD: begin
                    if (r_instr_valid && instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= halt ? S_HALTED : S_FETCH;
                    end
                end
                S_HALTED: begin
                    r_instr_valid <= 1'b0;
                    if (!halt) begin
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector and sequence bench for fetch_unit
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    always #5 clk = ~clk;

    logic       imem_req, imem_ack, redirect_valid, halt, instr_valid, instr_ready;
    logic [7:0] imem_addr, imem_rdata, redirect_pc, instr_pc;
    logic [4:0] instr_opcode;
    logic [2:0] instr_operand;

    logic       req2, ack2, valid2;
    logic [7:0] addr2, rdata2, ipc2;
    logic [4:0] op2;
    logic [2:0] opd2;

    logic [7:0] mem [256];
    logic [3:0] wcnt;
    int         mem_wait = 0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] wrap_q [$];

    fetch_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_operand(instr_operand), .instr_pc(instr_pc)
    );

    fetch_unit #(.PC_WIDTH(8), .RESET_PC(8'hFE)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
        .redirect_valid(1'b0), .redirect_pc(8'h00), .halt(1'b0),
        .instr_valid(valid2), .instr_ready(1'b1),
        .instr_opcode(op2), .instr_operand(opd2), .instr_pc(ipc2)
    );

    // Memory model: ack comes mem_wait cycles after the request first appears.
    always @(posedge clk or posedge rst) begin
        if (rst)                       wcnt <= 4'd0;
        else if (!imem_req || imem_ack) wcnt <= 4'd0;
        else                           wcnt <= wcnt + 4'd1;
    end
    assign imem_ack   = imem_req && (int'(wcnt) >= mem_wait);
    assign imem_rdata = mem[imem_addr];
    assign ack2       = req2;
    assign rdata2     = mem[addr2];

    always @(negedge clk) begin
        if (!rst && valid2 && wrap_q.size() < 3) wrap_q.push_back(ipc2);
    end

    typedef struct {
        logic       ready;
        logic       e_valid;
        logic       e_req;
        logic [7:0] e_addr;
        logic [4:0] e_op;
        logic [2:0] e_opd;
        logic [7:0] e_ipc;
    } vec_t;

    function automatic logic [25:0] pk(input logic v, input logic r, input logic [7:0] a,
                                       input logic [4:0] op, input logic [2:0] opd, input logic [7:0] ipc);
        return {v, r, (r ? a : 8'h00), op, opd, ipc};
    endfunction

    function automatic logic [25:0] act();
        return pk(instr_valid, imem_req, imem_addr, instr_opcode, instr_operand, instr_pc);
    endfunction

    task automatic chk(input string name, input logic [25:0] a, input logic [25:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input logic [7:0] pc);
        int n = 0;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        chk(name, act(), pk(1'b1, 1'b0, 8'h00, mem[pc][7:3], mem[pc][2:0], pc));
    endtask

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        mem[0] = 8'h08;
        mem[1] = 8'h13;
        mem[2] = 8'hA5;

        vecs[0] = '{1'b1, 1'b0, 1'b1, 8'h00, 5'd0,  3'd0, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 5'd1,  3'd0, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 8'h01, 5'd1,  3'd0, 8'h00};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h00, 5'd2,  3'd3, 8'h01};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 8'h02, 5'd2,  3'd3, 8'h01};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 8'h00, 5'd20, 3'd5, 8'h02};

        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        halt           = 1'b0;
        instr_ready    = 1'b1;

        step();
        step();
        chk("reset_state", act(), pk(1'b0, 1'b0, 8'h00, 5'd0, 3'd0, 8'h00));
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            instr_ready = vecs[i].ready;
            step();
            chk($sformatf("seq_vec%0d", i), act(),
                pk(vecs[i].e_valid, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_op, vecs[i].e_opd, vecs[i].e_ipc));
        end

        // Backpressure in HOLD, then a fetch with three wait states.
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_hold", act(), pk(1'b1, 1'b0, 8'h00, 5'd20, 3'd5, 8'h02));
        end
        instr_ready = 1'b1;
        mem_wait    = 3;
        step();
        chk("bp_release", act(), pk(1'b0, 1'b1, 8'h03, 5'd20, 3'd5, 8'h02));
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_addr", act(), pk(1'b0, 1'b1, 8'h03, 5'd20, 3'd5, 8'h02));
        end
        step();
        chk("wait_capture", act(), pk(1'b1, 1'b0, 8'h00, mem[3][7:3], mem[3][2:0], 8'h03));
        for (int i = 0; i < 2; i++) begin
            step();
            chk("bp_hold2", act(), pk(1'b1, 1'b0, 8'h00, mem[3][7:3], mem[3][2:0], 8'h03));
        end
        instr_ready = 1'b1;
        step();
        chk("pc_advance", act(), pk(1'b0, 1'b1, 8'h04, mem[3][7:3], mem[3][2:0], 8'h03));

        // Redirect while the request for address 5 is outstanding.
        wait_valid("fetch4", 8'h04);
        step();
        chk("req5", act(), pk(1'b0, 1'b1, 8'h05, mem[4][7:3], mem[4][2:0], 8'h04));
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drain_addr", act(), pk(1'b0, 1'b1, 8'h05, mem[4][7:3], mem[4][2:0], 8'h04));
            step();
        end
        chk("drain_done", act(), pk(1'b0, 1'b1, 8'h40, mem[4][7:3], mem[4][2:0], 8'h04));
        mem_wait = 0;
        wait_valid("fetch40", 8'h40);

        // Redirect together with instr_ready in HOLD drops the buffered instruction.
        redirect_valid = 1'b1;
        redirect_pc    = 8'h80;
        step();
        redirect_valid = 1'b0;
        chk("hold_redirect", act(), pk(1'b0, 1'b1, 8'h80, mem[8'h40][7:3], mem[8'h40][2:0], 8'h40));
        wait_valid("fetch80", 8'h80);

        // Halt raised while waiting on ack: instruction still delivered, then park.
        mem_wait = 3;
        step();
        halt = 1'b1;
        wait_valid("halt_deliver", 8'h81);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halted", act(), pk(1'b0, 1'b0, 8'h00, mem[8'h81][7:3], mem[8'h81][2:0], 8'h81));
        end
        halt = 1'b0;
        step();
        chk("resume", act(), pk(1'b0, 1'b1, 8'h82, mem[8'h81][7:3], mem[8'h81][2:0], 8'h81));
        mem_wait = 0;
        wait_valid("fetch82", 8'h82);

        // Asynchronous reset in the middle of a FETCH.
        mem_wait = 3;
        step();
        chk("pre_rst", act(), pk(1'b0, 1'b1, 8'h83, mem[8'h82][7:3], mem[8'h82][2:0], 8'h82));
        #2 rst = 1'b1;
        #1 chk("async_rst", act(), pk(1'b0, 1'b0, 8'h00, 5'd0, 3'd0, 8'h00));
        step();
        rst = 1'b0;
        step();
        chk("rst_first_req", act(), pk(1'b0, 1'b1, 8'h00, 5'd0, 3'd0, 8'h00));
        mem_wait = 0;
        wait_valid("rst_fetch0", 8'h00);

        chk("wrap_count", 26'(wrap_q.size() >= 3), 26'd1);
        if (wrap_q.size() >= 3) begin
            chk("wrap0", 26'(wrap_q[0]), 26'h0FE);
            chk("wrap1", 26'(wrap_q[1]), 26'h0FF);
            chk("wrap2", 26'(wrap_q[2]), 26'h000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
